// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the 1-to-4 demux: one upstream port, four buffered
// downstream channels and their per-channel delivery counters.
interface demux_1_4_stream_if #(
   parameter int WIDTH = 4
);
   logic             up_valid;
   logic [WIDTH-1:0] up_data;
   logic [1:0]       up_sel;
   logic             up_ready;
   logic [WIDTH-1:0] d0, d1, d2, d3;
   logic [3:0]       dn_valid;
   logic [3:0]       dn_ready;
   logic [7:0]       cnt0, cnt1, cnt2, cnt3;

   modport master (
      output up_valid, up_data, up_sel, dn_ready,
      input  up_ready, d0, d1, d2, d3, dn_valid, cnt0, cnt1, cnt2, cnt3
   );

   modport slave (
      input  up_valid, up_data, up_sel, dn_ready,
      output up_ready, d0, d1, d2, d3, dn_valid, cnt0, cnt1, cnt2, cnt3
   );
endinterface

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demux: each channel has a one-entry output register that can
// drain and reload in the same cycle, plus a modulo-256 delivery counter.
module demux_1_4_stream #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   demux_1_4_stream_if.slave bus
);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [3:0] w_valid;
   logic       w_up_ready;

   // Selected slot can accept when it is empty or is being drained this cycle.
   assign w_up_ready = !w_valid[bus.up_sel] || bus.dn_ready[bus.up_sel];

   for (genvar g = 0; g < 4; g++) begin : g_ch
      logic [0:0]       r_state;
      logic [WIDTH-1:0] r_data;
      logic [7:0]       r_cnt;
      logic             w_load;
      logic             w_deliver;

      assign w_load    = bus.up_valid && w_up_ready && (bus.up_sel == 2'(g));
      assign w_deliver = (r_state == ST_FULL) && bus.dn_ready[g];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
         end else begin
            if (w_load) begin
               r_state <= ST_FULL;
               r_data  <= bus.up_data;
            end else if (w_deliver) begin
               r_state <= ST_EMPTY;
            end
            if (w_deliver) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign w_valid = {g_ch[3].r_state == ST_FULL, g_ch[2].r_state == ST_FULL,
                     g_ch[1].r_state == ST_FULL, g_ch[0].r_state == ST_FULL};

   assign bus.up_ready = w_up_ready;
   assign bus.dn_valid = w_valid;
   assign bus.d0       = g_ch[0].r_data;
   assign bus.d1       = g_ch[1].r_data;
   assign bus.d2       = g_ch[2].r_data;
   assign bus.d3       = g_ch[3].r_data;
   assign bus.cnt0     = g_ch[0].r_cnt;
   assign bus.cnt1     = g_ch[1].r_cnt;
   assign bus.cnt2     = g_ch[2].r_cnt;
   assign bus.cnt3     = g_ch[3].r_cnt;
endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 Parameter: WIDTH, default 4, data width of every data port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 up_valid  input  1  upstream word present.
REQ-005 up_data  input  WIDTH  upstream word.
REQ-006 up_sel  input  2  destination channel 0..3, qualified by up_valid.
REQ-007 up_ready  output  1  block accepts the upstream word this cycle.
REQ-008 d0, d1, d2, d3  output  WIDTH each  per-channel data out.
REQ-009 dn_valid  output  4  bit i = channel i holds a word.
REQ-010 dn_ready  input  4  bit i = channel i consumer accepts this cycle.
REQ-011 cnt0, cnt1, cnt2, cnt3  output  8 each  words delivered per channel, modulo 256.

Function
REQ-012 Each channel i SHALL have a one-entry output register that drives di and dn_valid[i].
REQ-013 An upstream transfer SHALL occur in a cycle when up_valid and up_ready are both 1.
REQ-014 A channel-i delivery SHALL occur in a cycle when dn_valid[i] and dn_ready[i] are both 1.
REQ-015 up_ready SHALL be combinational: 1 iff dn_valid[up_sel] is 0, or dn_ready[up_sel] is 1 (slot drains this cycle).
REQ-016 up_ready SHALL depend only on up_sel, dn_valid and dn_ready, never on up_valid.
REQ-017 On upstream transfer, channel up_sel's register SHALL load up_data and set dn_valid[up_sel] to 1 on the next edge; latency is exactly 1 cycle.
REQ-018 Simultaneous delivery and reload of the same channel SHALL leave dn_valid at 1 with the new word; no bubble occurs and no word is lost.
REQ-019 On delivery with no reload, dn_valid[i] SHALL clear on the next edge.
REQ-020 Channels not addressed by up_sel SHALL hold data and valid unchanged except for their own delivery.
REQ-021 Each channel is a two-state machine (EMPTY, FULL): EMPTY->FULL on load; FULL->EMPTY on delivery without reload; FULL->FULL on delivery with reload or while stalled.
REQ-022 While dn_valid[i] is 1 and dn_ready[i] is 0, di SHALL be stable.
REQ-023 cnti SHALL increment by 1 on each channel-i delivery and wrap from 255 to 0.
REQ-024 di contents SHALL be don't-care while dn_valid[i] is 0; benches check di only while valid.
REQ-025 Word order per channel SHALL match upstream acceptance order.

Reset
REQ-026 While rst_n is 0 at a rising edge, all dn_valid bits, d0..d3 and cnt0..cnt3 SHALL become 0 on that edge.
REQ-027 While rst_n is 0, up_ready SHALL still follow REQ-015; words accepted in that cycle SHALL be discarded.
REQ-028 Reset asserted mid-operation SHALL drop all buffered words; no delivery is counted on that edge.
REQ-029 Only rst_n SHALL initialise state; there is no asynchronous path.

Verification
REQ-030 Reset, then up_valid=1, up_data=A, up_sel=2, dn_ready=0 -> next cycle dn_valid=0100, d2=A, up_ready=0 while up_sel=2, up_ready=1 for up_sel=0.
REQ-031 Channel 1 full, dn_ready[1]=1, upstream B to sel=1 in the same cycle -> dn_valid[1] stays 1, d1=B next cycle, cnt1 increments by 1.
REQ-032 Send A,B,C,D to sels 0,1,2,3 on consecutive cycles with dn_ready=1111 -> each di appears one cycle after acceptance, each cnti=1.
REQ-033 Hold dn_ready[3]=0 with channel 3 full for 5 cycles -> d3 constant, up_ready=0 whenever up_sel=3, other channels still flow.
REQ-034 Deliver 256 words on channel 0 -> cnt0 returns to 0; deliver one more -> cnt0=1.
REQ-035 All four channels full, rst_n=0 for one edge -> dn_valid=0000, cnt0..cnt3=0, d0..d3=0 afterwards.
